// File: rtl/alu_arbiter.sv
// Two-requester round-robin arbiter in front of a shared combinational ALU.
// A one-entry response buffer captures each granted result; it supports one grant per cycle.
module alu_arbiter #(
  parameter int OPERAND_LENGTH = 32,
  parameter int PC_LENGTH      = 12
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic                      req0_valid,
  output logic                      req0_ready,
  input  logic [OPERAND_LENGTH-1:0] req0_opd1,
  input  logic [OPERAND_LENGTH-1:0] req0_opd2,
  input  logic [OPERAND_LENGTH-1:0] req0_opd3,
  input  logic [OPERAND_LENGTH-1:0] req0_opd4,
  input  logic [PC_LENGTH-1:0]      req0_pc,
  input  logic [6:0]                req0_ctrl,

  input  logic                      req1_valid,
  output logic                      req1_ready,
  input  logic [OPERAND_LENGTH-1:0] req1_opd1,
  input  logic [OPERAND_LENGTH-1:0] req1_opd2,
  input  logic [OPERAND_LENGTH-1:0] req1_opd3,
  input  logic [OPERAND_LENGTH-1:0] req1_opd4,
  input  logic [PC_LENGTH-1:0]      req1_pc,
  input  logic [6:0]                req1_ctrl,

  output logic [OPERAND_LENGTH-1:0] alu_opd1,
  output logic [OPERAND_LENGTH-1:0] alu_opd2,
  output logic [OPERAND_LENGTH-1:0] alu_opd3,
  output logic [OPERAND_LENGTH-1:0] alu_opd4,
  output logic [PC_LENGTH-1:0]      alu_pc,
  output logic                      alu_pc_select,
  output logic [2:0]                alu_op_select,
  output logic [1:0]                alu_mux2_select,
  output logic                      alu_mux1_select,

  input  logic [OPERAND_LENGTH-1:0] alu_result,
  input  logic [OPERAND_LENGTH-1:0] comp_result,

  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic                      rsp_id,
  output logic [OPERAND_LENGTH-1:0] rsp_alu_result,
  output logic [OPERAND_LENGTH-1:0] rsp_comp_result
);

  // state | meaning
  // EMPTY | no response held, rsp_valid=0
  // FULL  | response held, rsp_valid=1 until rsp_ready
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic                      last_q, last_d;
  logic                      rsp_id_q, rsp_id_d;
  logic [OPERAND_LENGTH-1:0] rsp_alu_q, rsp_alu_d;
  logic [OPERAND_LENGTH-1:0] rsp_comp_q, rsp_comp_d;

  logic can_accept;
  logic grant;
  logic grant_id;

  // Buffer frees up in the same cycle its current entry is consumed.
  assign can_accept = (state_q == EMPTY) || rsp_ready;
  assign grant      = can_accept && (req0_valid || req1_valid);

  always_comb begin
    grant_id = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_id = ~last_q;
    end else if (req1_valid) begin
      grant_id = 1'b1;
    end
  end

  always_comb begin
    alu_opd1        = '0;
    alu_opd2        = '0;
    alu_opd3        = '0;
    alu_opd4        = '0;
    alu_pc          = '0;
    alu_pc_select   = 1'b0;
    alu_op_select   = 3'b000;
    alu_mux2_select = 2'b00;
    alu_mux1_select = 1'b0;
    if (grant) begin
      if (grant_id) begin
        alu_opd1        = req1_opd1;
        alu_opd2        = req1_opd2;
        alu_opd3        = req1_opd3;
        alu_opd4        = req1_opd4;
        alu_pc          = req1_pc;
        alu_pc_select   = req1_ctrl[6];
        alu_op_select   = req1_ctrl[5:3];
        alu_mux2_select = req1_ctrl[2:1];
        alu_mux1_select = req1_ctrl[0];
      end else begin
        alu_opd1        = req0_opd1;
        alu_opd2        = req0_opd2;
        alu_opd3        = req0_opd3;
        alu_opd4        = req0_opd4;
        alu_pc          = req0_pc;
        alu_pc_select   = req0_ctrl[6];
        alu_op_select   = req0_ctrl[5:3];
        alu_mux2_select = req0_ctrl[2:1];
        alu_mux1_select = req0_ctrl[0];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      last_q     <= 1'b1;
      rsp_id_q   <= 1'b0;
      rsp_alu_q  <= '0;
      rsp_comp_q <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rsp_id_q   <= rsp_id_d;
      rsp_alu_q  <= rsp_alu_d;
      rsp_comp_q <= rsp_comp_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rsp_id_d   = rsp_id_q;
    rsp_alu_d  = rsp_alu_q;
    rsp_comp_d = rsp_comp_q;
    case (state_q)
      EMPTY: begin
        if (grant) state_d = FULL;
      end
      FULL: begin
        if (rsp_ready && !grant) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
    if (grant) begin
      last_d     = grant_id;
      rsp_id_d   = grant_id;
      rsp_alu_d  = alu_result;
      rsp_comp_d = comp_result;
    end
  end

  always_comb begin
    rsp_valid       = (state_q == FULL);
    rsp_id          = rsp_id_q;
    rsp_alu_result  = rsp_alu_q;
    rsp_comp_result = rsp_comp_q;
    req0_ready      = grant && !grant_id;
    req1_ready      = grant && grant_id;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small behavioural ALU model on the shared port.
// Inputs change 1ns after the rising edge; outputs are checked a further ns later.
module tb_alu_arbiter;
  localparam int OL = 32;
  localparam int PL = 12;

  logic          clk;
  logic          rst_n;
  logic          req0_valid, req0_ready, req1_valid, req1_ready;
  logic [OL-1:0] req0_opd1, req0_opd2, req0_opd3, req0_opd4;
  logic [OL-1:0] req1_opd1, req1_opd2, req1_opd3, req1_opd4;
  logic [PL-1:0] req0_pc, req1_pc;
  logic [6:0]    req0_ctrl, req1_ctrl;
  logic [OL-1:0] alu_opd1, alu_opd2, alu_opd3, alu_opd4;
  logic [PL-1:0] alu_pc;
  logic          alu_pc_select, alu_mux1_select;
  logic [2:0]    alu_op_select;
  logic [1:0]    alu_mux2_select;
  logic [OL-1:0] alu_result, comp_result;
  logic          rsp_valid, rsp_ready, rsp_id;
  logic [OL-1:0] rsp_alu_result, rsp_comp_result;

  int n_checks = 0;
  int n_fail   = 0;

  alu_arbiter #(.OPERAND_LENGTH(OL), .PC_LENGTH(PL)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready),
    .req0_opd1(req0_opd1), .req0_opd2(req0_opd2), .req0_opd3(req0_opd3), .req0_opd4(req0_opd4),
    .req0_pc(req0_pc), .req0_ctrl(req0_ctrl),
    .req1_valid(req1_valid), .req1_ready(req1_ready),
    .req1_opd1(req1_opd1), .req1_opd2(req1_opd2), .req1_opd3(req1_opd3), .req1_opd4(req1_opd4),
    .req1_pc(req1_pc), .req1_ctrl(req1_ctrl),
    .alu_opd1(alu_opd1), .alu_opd2(alu_opd2), .alu_opd3(alu_opd3), .alu_opd4(alu_opd4),
    .alu_pc(alu_pc), .alu_pc_select(alu_pc_select), .alu_op_select(alu_op_select),
    .alu_mux2_select(alu_mux2_select), .alu_mux1_select(alu_mux1_select),
    .alu_result(alu_result), .comp_result(comp_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_alu_result(rsp_alu_result), .rsp_comp_result(rsp_comp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: A = pc or opd1/opd3, B = opd2/opd3/opd4/1; comp is unsigned A<B.
  logic [OL-1:0] alu_a, alu_b;
  always_comb begin
    alu_a = alu_mux1_select ? alu_opd3 : alu_opd1;
    if (alu_pc_select) alu_a = {{(OL-PL){1'b0}}, alu_pc};
    case (alu_mux2_select)
      2'b00:   alu_b = alu_opd2;
      2'b01:   alu_b = alu_opd3;
      2'b10:   alu_b = alu_opd4;
      default: alu_b = 1;
    endcase
    case (alu_op_select)
      3'b000:  alu_result = alu_a + alu_b;
      3'b001:  alu_result = alu_a - alu_b;
      3'b010:  alu_result = alu_a & alu_b;
      3'b011:  alu_result = alu_a | alu_b;
      default: alu_result = alu_a ^ alu_b;
    endcase
    comp_result = (alu_a < alu_b) ? 1 : 0;
  end

  task automatic clear_reqs();
    req0_valid = 0; req1_valid = 0;
    req0_opd1 = 0; req0_opd2 = 0; req0_opd3 = 0; req0_opd4 = 0; req0_pc = 0; req0_ctrl = 0;
    req1_opd1 = 0; req1_opd2 = 0; req1_opd3 = 0; req1_opd4 = 0; req1_pc = 0; req1_ctrl = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    clear_reqs();
    rsp_ready = 1;
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    clear_reqs();
    rsp_ready = 0;
    tick();
    tick();
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_alu_result !== '0 || rsp_comp_result !== '0) begin
      n_fail++;
      $display("FAIL reset_rsp: valid=%b id=%b res=%0h comp=%0h, required all 0", rsp_valid, rsp_id, rsp_alu_result, rsp_comp_result);
    end
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ready: r0=%b r1=%b, required 0 0", req0_ready, req1_ready);
    end
    n_checks++;
    if ({alu_opd1, alu_opd2, alu_opd3, alu_opd4, alu_pc, alu_pc_select, alu_op_select, alu_mux2_select, alu_mux1_select} !== '0) begin
      n_fail++;
      $display("FAIL reset_alu_zero: opd1=%0h opd2=%0h pc=%0h op=%0h, required all 0", alu_opd1, alu_opd2, alu_pc, alu_op_select);
    end
    @(posedge clk);
    #1;
    rst_n = 1;
    rsp_ready = 1;
  endtask

  task automatic test_single_req0();
    req0_valid = 1; req0_opd1 = 5; req0_opd2 = 3; req0_opd3 = 77; req0_ctrl = 7'h00;
    req1_opd1 = 99; req1_opd2 = 99;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL single_ready: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    n_checks++;
    if (alu_opd1 !== 32'd5 || alu_opd2 !== 32'd3 || alu_opd3 !== 32'd77) begin
      n_fail++;
      $display("FAIL single_alu_mux: opd1=%0d opd2=%0d opd3=%0d, required 5 3 77", alu_opd1, alu_opd2, alu_opd3);
    end
    tick();
    req0_valid = 0;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_alu_result !== 32'd8 || rsp_comp_result !== 32'd0) begin
      n_fail++;
      $display("FAIL single_rsp: valid=%b id=%b res=%0d comp=%0d, required 1 0 8 0", rsp_valid, rsp_id, rsp_alu_result, rsp_comp_result);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_drain: valid=%b, required 0", rsp_valid);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_ids;
    exp_ids = 4'b1010;  // bit i = expected grant in cycle i: 0,1,0,1
    do_reset();
    req0_valid = 1; req1_valid = 1;
    req0_opd1 = 100; req0_opd2 = 1;
    req1_opd1 = 200; req1_opd2 = 2;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (req0_ready !== ~exp_ids[i] || req1_ready !== exp_ids[i]) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: r0=%b r1=%b, required r1=%b", i, req0_ready, req1_ready, exp_ids[i]);
      end
      tick();
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_ids[i] ||
          rsp_alu_result !== (exp_ids[i] ? 32'd202 : 32'd101)) begin
        n_fail++;
        $display("FAIL rr_rsp[%0d]: valid=%b id=%b res=%0d, required id=%b", i, rsp_valid, rsp_id, rsp_alu_result, exp_ids[i]);
      end
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_pc_and_sub();
    req1_valid = 1; req1_ctrl = 7'h40; req1_pc = 12'h100; req1_opd1 = 32'h55; req1_opd2 = 4;
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_alu_result !== 32'h104) begin
      n_fail++;
      $display("FAIL pc_add: valid=%b id=%b res=%0h, required 1 1 104", rsp_valid, rsp_id, rsp_alu_result);
    end
    req1_ctrl = 7'h08; req1_opd1 = 10; req1_opd2 = 3;
    tick();
    n_checks++;
    if (rsp_id !== 1'b1 || rsp_alu_result !== 32'd7) begin
      n_fail++;
      $display("FAIL sub: id=%b res=%0d, required 1 7", rsp_id, rsp_alu_result);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_back_to_back();
    req0_valid = 1; req0_opd1 = 2; req0_opd2 = 9; req0_ctrl = 7'h00;
    tick();
    n_checks++;
    if (rsp_alu_result !== 32'd11 || rsp_comp_result !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_first: res=%0d comp=%0d, required 11 1", rsp_alu_result, rsp_comp_result);
    end
    req0_opd1 = 4; req0_opd3 = 6; req0_ctrl = 7'h02;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready_while_full: r0=%b, required 1", req0_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_alu_result !== 32'd10 || rsp_comp_result !== 32'd1) begin
      n_fail++;
      $display("FAIL b2b_second: valid=%b res=%0d comp=%0d, required 1 10 1", rsp_valid, rsp_alu_result, rsp_comp_result);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_backpressure();
    do_reset();
    req0_valid = 1; req0_opd1 = 1; req0_opd2 = 2;
    tick();
    rsp_ready = 0;
    req1_valid = 1; req1_opd1 = 20; req1_opd2 = 5;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++;
      if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || rsp_valid !== 1'b1 ||
          rsp_id !== 1'b0 || rsp_alu_result !== 32'd3) begin
        n_fail++;
        $display("FAIL stall[%0d]: r0=%b r1=%b valid=%b id=%b res=%0d, required 0 0 1 0 3", i, req0_ready, req1_ready, rsp_valid, rsp_id, rsp_alu_result);
      end
      tick();
    end
    rsp_ready = 1;
    #1;
    n_checks++;
    if (req0_ready !== 1'b0 || req1_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_grant: r0=%b r1=%b, required 0 1", req0_ready, req1_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_alu_result !== 32'd25) begin
      n_fail++;
      $display("FAIL stall_release_rsp: valid=%b id=%b res=%0d, required 1 1 25", rsp_valid, rsp_id, rsp_alu_result);
    end
    clear_reqs();
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req1_valid = 1; req1_opd1 = 7; req1_opd2 = 1;
    tick();
    clear_reqs();
    rsp_ready = 0;
    #2;
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_alu_result !== 32'd8) begin
      n_fail++;
      $display("FAIL arst_pre: valid=%b id=%b res=%0d, required 1 1 8", rsp_valid, rsp_id, rsp_alu_result);
    end
    rst_n = 0;
    #1;
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_alu_result !== '0 || rsp_comp_result !== '0) begin
      n_fail++;
      $display("FAIL arst_immediate: valid=%b id=%b res=%0d, required 0 0 0", rsp_valid, rsp_id, rsp_alu_result);
    end
    tick();
    rst_n = 1;
    rsp_ready = 1;
    req0_valid = 1; req1_valid = 1;
    req0_opd1 = 30; req0_opd2 = 3;
    req1_opd1 = 40; req1_opd2 = 4;
    #1;
    n_checks++;
    if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL arst_first_grant: r0=%b r1=%b, required 1 0", req0_ready, req1_ready);
    end
    tick();
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_alu_result !== 32'd33) begin
      n_fail++;
      $display("FAIL arst_first_rsp: valid=%b id=%b res=%0d, required 1 0 33", rsp_valid, rsp_id, rsp_alu_result);
    end
    clear_reqs();
    tick();
  endtask

  initial begin
    test_reset();
    test_single_req0();
    test_round_robin();
    test_pc_and_sub();
    test_back_to_back();
    test_backpressure();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have parameter OPERAND_LENGTH, default 32, meaning ALU operand and result width.
REQ-002 The block SHALL have parameter PC_LENGTH, default 12, meaning program-counter width.
REQ-003 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit, rising-edge clock.
REQ-005 The block SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-006 Per requester N in {0,1}, the block SHALL have port reqN_valid, input, 1 bit, request present.
REQ-007 Per requester N, the block SHALL have port reqN_ready, output, 1 bit, request accepted this cycle.
REQ-008 Per requester N, the block SHALL have ports reqN_opd1..reqN_opd4, input, OPERAND_LENGTH bits each, ALU operands.
REQ-009 Per requester N, the block SHALL have port reqN_pc, input, PC_LENGTH bits, PC operand.
REQ-010 Per requester N, the block SHALL have port reqN_ctrl, input, 7 bits: [6] pc_select, [5:3] op_select, [2:1] mux2_select, [0] mux1_select.
REQ-011 The block SHALL have ports alu_opd1..alu_opd4, output, OPERAND_LENGTH bits each, to the shared ALU.
REQ-012 The block SHALL have port alu_pc, output, PC_LENGTH bits, to the shared ALU.
REQ-013 The block SHALL have ports alu_pc_select (1 bit), alu_op_select (3 bits), alu_mux2_select (2 bits) and alu_mux1_select (1 bit), outputs, to the shared ALU.
REQ-014 The block SHALL have ports alu_result and comp_result, input, OPERAND_LENGTH bits each, from the ALU (combinational).
REQ-015 The block SHALL have ports rsp_valid (output, 1 bit), rsp_ready (input, 1 bit), rsp_id (output, 1 bit, granted requester), rsp_alu_result (output, OPERAND_LENGTH bits) and rsp_comp_result (output, OPERAND_LENGTH bits).

Function
REQ-016 The block SHALL hold a one-entry response buffer with two states, EMPTY (rsp_valid=0) and FULL (rsp_valid=1).
REQ-017 The buffer SHALL be able to accept a request when EMPTY, or when FULL and rsp_ready=1 in the same cycle.
REQ-018 When able to accept, the block SHALL grant exactly one valid requester; with one valid requester, that requester is granted.
REQ-019 With both requesters valid, the block SHALL grant the requester not granted last (round-robin); the last-grant register updates only on a grant.
REQ-020 reqN_ready SHALL be 1 only for the granted requester and SHALL depend combinationally on reqN_valid, buffer state and rsp_ready; requesters SHALL NOT make valid depend on ready.
REQ-021 The alu_* outputs SHALL combinationally carry the granted requester's operands and ctrl fields, and SHALL be all-zero when there is no grant.
REQ-022 On a grant, at the next rising edge the block SHALL capture alu_result, comp_result and the grant ID into rsp_*, with rsp_valid=1 (latency: 1 cycle).
REQ-023 A response SHALL complete when rsp_valid=1 and rsp_ready=1 at a rising edge; with no simultaneous grant, the buffer goes EMPTY.
REQ-024 With a simultaneous response completion and new grant, the buffer SHALL stay FULL and load the new result (back-to-back throughput of 1 per cycle).
REQ-025 While FULL and rsp_ready=0, rsp_* SHALL be held stable and both reqN_ready SHALL be 0.
REQ-026 The block SHALL not modify operand values; all arithmetic is performed by the external ALU.

Reset
REQ-027 While rst_n=0, regardless of clk: rsp_valid=0, rsp_id=0, rsp_alu_result=0, rsp_comp_result=0, and last-grant=1 so that requester 0 wins the first contention.
REQ-028 Reset asserted while FULL SHALL discard the held response immediately; there is no replay after reset release.

Verification
REQ-029 Reset, with both reqN_valid=0 -> rsp_valid=0, reqN_ready=0, all alu_* outputs 0.
REQ-030 req0 only, ctrl op_select=000 and mux2_select=00, opd1=5, opd2=3, rsp_ready=1 -> req0_ready=1 the same cycle; next cycle rsp_valid=1, rsp_id=0, rsp_alu_result=8.
REQ-031 Both requesters valid for 4 cycles, rsp_ready=1 -> grants 0,1,0,1; rsp_id sequence 0,1,0,1 one cycle later.
REQ-032 req1 with pc_select=1, pc=0x100, opd2=4 -> rsp_alu_result=0x104; then op_select=001, opd1=10, opd2=3 -> 7.
REQ-033 FULL with rsp_ready=0 for 3 cycles and both requesters valid -> rsp_* unchanged and reqN_ready=0; when rsp_ready=1, a grant is issued in that same cycle and the new result appears next cycle.
REQ-034 rst_n pulled low mid-cycle while FULL -> rsp_valid=0 immediately, without waiting for a clk edge; after release, with both requesters valid, the first grant goes to requester 0.
